// File: rtl/switch_pkg.sv
// Shared switch-fabric definitions: default port count, port index type and cyclic index increment.
package switch_pkg;

  localparam int NUM_PORTS_DEFAULT = 4;
  localparam int PORT_IDX_W = $clog2(NUM_PORTS_DEFAULT);

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  // Explicit wrap so non-power-of-two port counts never rely on truncation.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, searched cyclically.
module rr_arbiter
  import switch_pkg::*;
#(
  parameter int N = NUM_PORTS_DEFAULT,
  parameter type idx_t = port_idx_t
) (
  input  logic [N-1:0] req,
  input  idx_t         ptr,
  output logic         valid,
  output idx_t         idx
);

  idx_t cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = ptr;
    for (int k = 0; k < N; k++) begin
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
      cand = idx_t'(wrap_inc(int'(cand), N));
    end
  end

endmodule

// File: rtl/voq_crossbar_scheduler.sv
// Single-iteration iSLIP crossbar scheduler; each match is held until the egress port signals end of frame.
// Define SCHED_AGE_GUARD_EN to let inputs waiting AGE_LIMIT cycles jump ahead of the grant round-robin order.
module voq_crossbar_scheduler
  import switch_pkg::*;
#(
  parameter int  NUM_PORTS = NUM_PORTS_DEFAULT,
  parameter int  AGE_LIMIT = 16,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                           switch_clk,
  input  logic                           switch_rst,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] voq_req_i,
  input  logic [NUM_PORTS-1:0]           egress_ready_i,
  input  logic [NUM_PORTS-1:0]           xfer_done_i,
  output logic [NUM_PORTS-1:0]           grant_valid_o,
  output logic [NUM_PORTS*IDX_W-1:0]     grant_out_o,
  output logic [NUM_PORTS-1:0]           out_busy_o
);

  typedef logic [IDX_W-1:0] idx_t;

  logic [NUM_PORTS-1:0] busy_reg, busy_next;
  logic [NUM_PORTS-1:0] matched_reg, matched_next;
  idx_t owner_reg [NUM_PORTS];
  idx_t owner_next [NUM_PORTS];
  idx_t dest_reg [NUM_PORTS];
  idx_t dest_next [NUM_PORTS];
  idx_t gptr_reg [NUM_PORTS];
  idx_t gptr_next [NUM_PORTS];
  idx_t aptr_reg [NUM_PORTS];
  idx_t aptr_next [NUM_PORTS];

  logic [NUM_PORTS-1:0] out_elig;
  logic [NUM_PORTS-1:0] grant_req [NUM_PORTS];
  logic [NUM_PORTS-1:0] rr_valid;
  idx_t                 rr_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0] gnt_valid;
  idx_t                 gnt_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0] acc_req [NUM_PORTS];
  logic [NUM_PORTS-1:0] acc_valid;
  idx_t                 acc_idx [NUM_PORTS];

  assign out_elig = ~busy_reg & egress_ready_i;

  // grant_req is indexed [output][input]; acc_req is indexed [input][output].
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        grant_req[j][i] = voq_req_i[i*NUM_PORTS + j] && !matched_reg[i] && out_elig[j];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        acc_req[i][j] = gnt_valid[j] && (gnt_idx[j] == idx_t'(i));
      end
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    rr_arbiter #(.N(NUM_PORTS), .idx_t(idx_t)) u_grant_arb (
      .req   (grant_req[gi]),
      .ptr   (gptr_reg[gi]),
      .valid (rr_valid[gi]),
      .idx   (rr_idx[gi])
    );
    rr_arbiter #(.N(NUM_PORTS), .idx_t(idx_t)) u_accept_arb (
      .req   (acc_req[gi]),
      .ptr   (aptr_reg[gi]),
      .valid (acc_valid[gi]),
      .idx   (acc_idx[gi])
    );
    assign grant_out_o[gi*IDX_W +: IDX_W] = dest_reg[gi];
  end

`ifdef SCHED_AGE_GUARD_EN
  localparam int WAIT_W = $clog2(AGE_LIMIT + 1);

  logic [WAIT_W-1:0]    wait_cnt_reg [NUM_PORTS];
  logic [WAIT_W-1:0]    wait_cnt_next [NUM_PORTS];
  logic [NUM_PORTS-1:0] aged;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      aged[i] = (wait_cnt_reg[i] == WAIT_W'(AGE_LIMIT));
    end
    for (int j = 0; j < NUM_PORTS; j++) begin
      gnt_valid[j] = rr_valid[j];
      gnt_idx[j]   = rr_idx[j];
      // Descending scan so the lowest-index aged requester is the one left standing.
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (grant_req[j][i] && aged[i]) begin
          gnt_valid[j] = 1'b1;
          gnt_idx[j]   = idx_t'(i);
        end
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      wait_cnt_next[i] = wait_cnt_reg[i];
      if (acc_valid[i]) begin
        wait_cnt_next[i] = '0;
      end else if (!matched_reg[i] && !aged[i] &&
                   |(voq_req_i[i*NUM_PORTS +: NUM_PORTS] & out_elig)) begin
        wait_cnt_next[i] = wait_cnt_reg[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge switch_clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      wait_cnt_reg[i] <= switch_rst ? '0 : wait_cnt_next[i];
    end
  end
`else
  logic unused_age_limit;
  assign unused_age_limit = (AGE_LIMIT != 0);
  assign gnt_valid = rr_valid;
  assign gnt_idx   = rr_idx;
`endif

  // Completions and new matches touch disjoint ports: done needs busy, accept needs free.
  always_comb begin
    busy_next    = busy_reg;
    matched_next = matched_reg;
    owner_next   = owner_reg;
    dest_next    = dest_reg;
    gptr_next    = gptr_reg;
    aptr_next    = aptr_reg;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (xfer_done_i[j] && busy_reg[j]) begin
        busy_next[j]               = 1'b0;
        matched_next[owner_reg[j]] = 1'b0;
        dest_next[owner_reg[j]]    = '0;
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (acc_valid[i]) begin
        matched_next[i]          = 1'b1;
        dest_next[i]             = acc_idx[i];
        busy_next[acc_idx[i]]    = 1'b1;
        owner_next[acc_idx[i]]   = idx_t'(i);
        gptr_next[acc_idx[i]]    = idx_t'(wrap_inc(i, NUM_PORTS));
        aptr_next[i]             = idx_t'(wrap_inc(int'(acc_idx[i]), NUM_PORTS));
      end
    end
  end

  always_ff @(posedge switch_clk) begin
    if (switch_rst) begin
      busy_reg    <= '0;
      matched_reg <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        owner_reg[i] <= '0;
        dest_reg[i]  <= '0;
        gptr_reg[i]  <= '0;
        aptr_reg[i]  <= '0;
      end
    end else begin
      busy_reg    <= busy_next;
      matched_reg <= matched_next;
      owner_reg   <= owner_next;
      dest_reg    <= dest_next;
      gptr_reg    <= gptr_next;
      aptr_reg    <= aptr_next;
    end
  end

  assign grant_valid_o = matched_reg;
  assign out_busy_o    = busy_reg;

endmodule

// File: tb/tb_voq_crossbar_scheduler.sv
// Self-checking bench for voq_crossbar_scheduler: directed scenarios plus randomized traffic against a behavioural model.
module tb_voq_crossbar_scheduler;

  localparam int N       = 4;
  localparam int W       = 2;
  localparam int AGE_LIM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N*N-1:0] voq_req = '0;
  logic [N-1:0]  rdy  = '0;
  logic [N-1:0]  done = '0;
  logic [N-1:0]  gv;
  logic [N*W-1:0] go;
  logic [N-1:0]  ob;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model state: which input owns each output, where each input is going, and the round-robin pointers.
  bit m_busy [N];
  bit m_matched [N];
  int m_owner [N];
  int m_dest [N];
  int m_gptr [N];
  int m_aptr [N];
  int m_wait [N];

  voq_crossbar_scheduler #(.NUM_PORTS(N), .AGE_LIMIT(AGE_LIM)) dut (
    .switch_clk     (clk),
    .switch_rst     (rst),
    .voq_req_i      (voq_req),
    .egress_ready_i (rdy),
    .xfer_done_i    (done),
    .grant_valid_o  (gv),
    .grant_out_o    (go),
    .out_busy_o     (ob)
  );

  always #5 clk = ~clk;

  task automatic model_step(input logic [N*N-1:0] req, input logic [N-1:0] rdy_v,
                            input logic [N-1:0] done_v, input logic rst_v);
    int  gsel [N];
    int  asel [N];
    bit  elig [N];
    bit  any_elig;
    int  cand;
    if (rst_v) begin
      for (int i = 0; i < N; i++) begin
        m_busy[i] = 0; m_matched[i] = 0; m_owner[i] = 0; m_dest[i] = 0;
        m_gptr[i] = 0; m_aptr[i] = 0; m_wait[i] = 0;
      end
      return;
    end
    for (int j = 0; j < N; j++) elig[j] = !m_busy[j] && rdy_v[j];
    for (int j = 0; j < N; j++) begin
      gsel[j] = -1;
      if (elig[j]) begin
`ifdef SCHED_AGE_GUARD_EN
        for (int i = 0; i < N; i++)
          if (gsel[j] < 0 && req[i*N+j] && !m_matched[i] && m_wait[i] == AGE_LIM) gsel[j] = i;
`endif
        for (int k = 0; k < N; k++) begin
          cand = (m_gptr[j] + k) % N;
          if (gsel[j] < 0 && req[cand*N+j] && !m_matched[cand]) gsel[j] = cand;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      asel[i] = -1;
      if (!m_matched[i]) begin
        for (int k = 0; k < N; k++) begin
          cand = (m_aptr[i] + k) % N;
          if (asel[i] < 0 && gsel[cand] == i) asel[i] = cand;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      any_elig = 0;
      for (int j = 0; j < N; j++) if (req[i*N+j] && elig[j]) any_elig = 1;
      if (!m_matched[i] && any_elig && m_wait[i] < AGE_LIM) m_wait[i]++;
    end
    for (int j = 0; j < N; j++) begin
      if (done_v[j] && m_busy[j]) begin
        m_matched[m_owner[j]] = 0;
        m_dest[m_owner[j]]    = 0;
        m_busy[j]             = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (asel[i] >= 0) begin
        m_matched[i]     = 1;
        m_dest[i]        = asel[i];
        m_busy[asel[i]]  = 1;
        m_owner[asel[i]] = i;
        m_gptr[asel[i]]  = (i + 1) % N;
        m_aptr[i]        = (asel[i] + 1) % N;
        m_wait[i]        = 0;
      end
    end
  endtask

  function automatic logic [N-1:0] exp_gv();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = m_matched[i];
    return v;
  endfunction

  function automatic logic [N-1:0] exp_ob();
    logic [N-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j] = m_busy[j];
    return v;
  endfunction

  function automatic logic [N*W-1:0] exp_go();
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) if (m_matched[i]) v[i*W +: W] = W'(m_dest[i]);
    return v;
  endfunction

  // One clock of stimulus: drive, let the edge happen, advance the model, settle past the edge.
  task automatic step(input logic [N*N-1:0] req, input logic [N-1:0] rdy_v,
                      input logic [N-1:0] done_v, input logic rst_v);
    voq_req = req; rdy = rdy_v; done = done_v; rst = rst_v;
    model_step(req, rdy_v, done_v, rst_v);
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc=%0d rst=%b req=%h rdy=%b done=%b -> gv=%b go=%h ob=%b",
             cyc, rst_v, req, rdy_v, done_v, gv, go, ob);
  endtask

  task automatic do_reset();
    step('0, '0, '0, 1'b1);
  endtask

  task automatic test_reset();
    step(16'($urandom), 4'hF, 4'($urandom), 1'b1);
    step(16'($urandom), 4'hF, 4'($urandom), 1'b1);
    n_cmp++; if (gv !== 4'b0000) begin n_bad++; $display("FAIL reset_gv: got %b want 0000", gv); end
    n_cmp++; if (go !== 8'h00) begin n_bad++; $display("FAIL reset_go: got %h want 00", go); end
    n_cmp++; if (ob !== 4'b0000) begin n_bad++; $display("FAIL reset_ob: got %b want 0000", ob); end
  endtask

  task automatic test_single();
    do_reset();
    step(16'h0004, 4'hF, 4'h0, 1'b0);
    n_cmp++; if (gv !== 4'b0001) begin n_bad++; $display("FAIL single_gv: got %b want 0001", gv); end
    n_cmp++; if (go !== 8'h02) begin n_bad++; $display("FAIL single_go: got %h want 02", go); end
    n_cmp++; if (ob !== 4'b0100) begin n_bad++; $display("FAIL single_ob: got %b want 0100", ob); end
    // Ignored completion on an idle port must not disturb the held match.
    step(16'h0004, 4'h0, 4'b1011, 1'b0);
    n_cmp++; if (gv !== 4'b0001 || ob !== 4'b0100) begin
      n_bad++; $display("FAIL single_hold: got gv=%b ob=%b want 0001/0100", gv, ob);
    end
    step(16'h0000, 4'hF, 4'b0100, 1'b0);
    n_cmp++; if (gv !== 4'b0000 || ob !== 4'b0000 || go !== 8'h00) begin
      n_bad++; $display("FAIL single_done: got gv=%b ob=%b go=%h want all 0", gv, ob, go);
    end
  endtask

  task automatic test_rr_order();
    int order [4] = '{0, 1, 2, 0};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(16'h0222, 4'hF, 4'h0, 1'b0);
      n_cmp++; if (gv !== 4'(1 << order[k]) || go !== 8'(1 << (W * order[k])) || ob !== 4'b0010) begin
        n_bad++; $display("FAIL rr_order_%0d: got gv=%b go=%h ob=%b want input %0d on output 1", k, gv, go, ob, order[k]);
      end
      // Request held during the done cycle cannot reuse the port being freed.
      step(16'h0222, 4'hF, 4'b0010, 1'b0);
      n_cmp++; if (gv !== 4'b0000 || ob !== 4'b0000) begin
        n_bad++; $display("FAIL rr_done_%0d: got gv=%b ob=%b want 0000/0000", k, gv, ob);
      end
    end
  endtask

  task automatic test_full_perm();
    do_reset();
    step(16'h1842, 4'hF, 4'h0, 1'b0);
    n_cmp++; if (gv !== 4'b1111) begin n_bad++; $display("FAIL perm_gv: got %b want 1111", gv); end
    n_cmp++; if (go !== 8'h39) begin n_bad++; $display("FAIL perm_go: got %h want 39", go); end
    n_cmp++; if (ob !== 4'b1111) begin n_bad++; $display("FAIL perm_ob: got %b want 1111", ob); end
  endtask

  task automatic test_refused_grant();
    do_reset();
    step(16'h0013, 4'hF, 4'h0, 1'b0);
    n_cmp++; if (gv !== 4'b0001 || go !== 8'h00 || ob !== 4'b0001) begin
      n_bad++; $display("FAIL refused_first: got gv=%b go=%h ob=%b want 0001/00/0001", gv, go, ob);
    end
    step(16'h0013, 4'hF, 4'h0, 1'b0);
    n_cmp++; if (ob !== 4'b0001 || gv !== 4'b0001) begin
      n_bad++; $display("FAIL refused_hold: got gv=%b ob=%b want 0001/0001", gv, ob);
    end
    step(16'h0013, 4'hF, 4'b0001, 1'b0);
    n_cmp++; if (gv !== 4'b0000 || ob !== 4'b0000) begin
      n_bad++; $display("FAIL refused_done: got gv=%b ob=%b want 0000/0000", gv, ob);
    end
    step(16'h0013, 4'hF, 4'h0, 1'b0);
    n_cmp++; if (gv !== 4'b0011 || go !== 8'h01 || ob !== 4'b0011) begin
      n_bad++; $display("FAIL refused_rematch: got gv=%b go=%h ob=%b want 0011/01/0011", gv, go, ob);
    end
  endtask

  task automatic test_not_ready();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(16'h0080, 4'b0111, 4'h0, 1'b0);
      n_cmp++; if (gv !== 4'b0000 || ob !== 4'b0000) begin
        n_bad++; $display("FAIL not_ready_%0d: got gv=%b ob=%b want 0000/0000", k, gv, ob);
      end
    end
    step(16'h0080, 4'b1111, 4'h0, 1'b0);
    n_cmp++; if (gv !== 4'b0010 || go !== 8'h0C || ob !== 4'b1000) begin
      n_bad++; $display("FAIL ready_match: got gv=%b go=%h ob=%b want 0010/0C/1000", gv, go, ob);
    end
    step(16'h0080, 4'b1111, 4'h0, 1'b1);
    n_cmp++; if (gv !== 4'b0000 || go !== 8'h00 || ob !== 4'b0000) begin
      n_bad++; $display("FAIL mid_match_reset: got gv=%b go=%h ob=%b want all 0", gv, go, ob);
    end
  endtask

  task automatic test_random();
    logic [N*N-1:0] r;
    logic [N-1:0]   rd, dn;
    logic           rs;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      r  = 16'($urandom) & 16'($urandom | $urandom);
      rd = 4'(~($urandom & $urandom & $urandom));
      dn = 4'($urandom) & 4'($urandom);
      rs = ($urandom_range(63) == 0);
      step(r, rd, dn, rs);
      n_cmp++; if (gv !== exp_gv()) begin n_bad++; $display("FAIL random_gv@%0d: got %b want %b", c, gv, exp_gv()); end
      n_cmp++; if (go !== exp_go()) begin n_bad++; $display("FAIL random_go@%0d: got %h want %h", c, go, exp_go()); end
      n_cmp++; if (ob !== exp_ob()) begin n_bad++; $display("FAIL random_ob@%0d: got %b want %b", c, ob, exp_ob()); end
    end
  endtask

`ifdef SCHED_AGE_GUARD_EN
  // Heavy contention on output 0 with short frames so waiting counters saturate and override pointer order.
  task automatic test_age_guard();
    logic [N*N-1:0] r;
    do_reset();
    for (int c = 0; c < 200; c++) begin
      r = 16'h1111 | (16'($urandom) & 16'($urandom) & 16'hEEEE);
      step(r, 4'($urandom) | 4'b0001, 4'b0001 | (4'($urandom) & 4'($urandom)), 1'b0);
      n_cmp++; if (gv !== exp_gv() || go !== exp_go() || ob !== exp_ob()) begin
        n_bad++; $display("FAIL age_guard@%0d: got gv=%b go=%h ob=%b want %b/%h/%b",
                          c, gv, go, ob, exp_gv(), exp_go(), exp_ob());
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rr_order();
    test_full_perm();
    test_refused_grant();
    test_not_ready();
    test_random();
`ifdef SCHED_AGE_GUARD_EN
    test_age_guard();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
